// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file.
// Default build has no forwarding; define REGFILE_BYPASS_EN to add it.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t R0 = 3'd0;
    localparam reg_addr_t R1 = 3'd1;
    localparam reg_addr_t R2 = 3'd2;
    localparam reg_addr_t R3 = 3'd3;
    localparam reg_addr_t R4 = 3'd4;
    localparam reg_addr_t R5 = 3'd5;
    localparam reg_addr_t R6 = 3'd6;
    localparam reg_addr_t R7 = 3'd7;

endpackage

// File: rtl/register_n.sv
// Single DATA_W-bit register with synchronous reset and load enable.
module register_n #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/register_file.sv
// Register file with two read ports, one write port and pending bits.
// Define REGFILE_BYPASS_EN for write-through forwarding to the read ports.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              any_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int FIRST = (ZERO_REG != 0) ? 1 : 0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  wsel;
    logic [DEPTH-1:0]  rsel;

    // One-hot write/reserve selects; entry 0 masked off when hardwired.
    always_comb begin
        wsel = '0;
        rsel = '0;
        for (int i = FIRST; i < DEPTH; i++) begin
            wsel[i] = we  && (waddr    == ADDR_W'(i));
            rsel[i] = rsv && (rsv_addr == ADDR_W'(i));
        end
    end

    genvar g;
    generate
        if (ZERO_REG != 0) begin : g_zero
            assign regs[0] = '0;
        end
        for (g = FIRST; g < DEPTH; g++) begin : g_reg
            register_n #(
                .DATA_W(DATA_W)
            ) u_reg (
                .clk(clk),
                .rst(rst),
                .en (wsel[g]),
                .d  (wdata),
                .q  (regs[g])
            );
        end
    endgenerate

    // Reserve is applied after release so a same-address collision stays pending.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending & ~wsel) | rsel;
    end

    assign any_busy = |pending;

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1   = wsel[raddr1];
    assign fwd2   = wsel[raddr2];
    assign rdata1 = fwd1 ? wdata : regs[raddr1];
    assign rdata2 = fwd2 ? wdata : regs[raddr2];
    assign busy1  = fwd1 ? rsel[raddr1] : pending[raddr1];
    assign busy2  = fwd2 ? rsel[raddr2] : pending[raddr2];
`else
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
    assign busy1  = pending[raddr1];
    assign busy2  = pending[raddr2];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default, ZERO_REG=0 and 16x16 instances.
module tb_register_file;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr1 = '0;
    logic [2:0] raddr2 = '0;
    logic       rsv = 1'b0;
    logic [2:0] rsv_addr = '0;

    logic [7:0] rdata1, rdata2;
    logic       busy1, busy2, any_busy;
    logic [7:0] nz_rdata1, nz_rdata2;
    logic       nz_busy1, nz_busy2, nz_any_busy;

    logic        w_we = 1'b0;
    logic [3:0]  w_waddr = '0;
    logic [15:0] w_wdata = '0;
    logic [3:0]  w_raddr1 = '0;
    logic [3:0]  w_raddr2 = '0;
    logic [15:0] w_rdata1, w_rdata2;
    logic        w_busy1, w_busy2, w_any_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .busy1(busy1), .busy2(busy2), .any_busy(any_busy)
    );

    register_file #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(nz_rdata1), .rdata2(nz_rdata2),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .busy1(nz_busy1), .busy2(nz_busy2), .any_busy(nz_any_busy)
    );

    register_file #(.DATA_W(16), .ADDR_W(4)) dut_w (
        .clk(clk), .rst(rst), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
        .raddr1(w_raddr1), .raddr2(w_raddr2),
        .rdata1(w_rdata1), .rdata2(w_rdata2),
        .rsv(1'b0), .rsv_addr(4'd0),
        .busy1(w_busy1), .busy2(w_busy2), .any_busy(w_any_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        rsv = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        idle();
        raddr1 = 3'd3;
        #1;
        checks++;
        if (rdata1 !== 8'h00 || busy1 !== 1'b0 || any_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: rdata=%h busy=%b any=%b want 00/0/0", rdata1, busy1, any_busy);
        end
        we = 1'b1; waddr = 3'd3; wdata = 8'hAA;
        rsv = 1'b1; rsv_addr = 3'd6;
        tick();
        idle();
        checks++;
        if (rdata1 !== 8'hAA || any_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: rdata=%h any=%b want aa/1", rdata1, any_busy);
        end
        rst = 1'b1; we = 1'b1; wdata = 8'h55; rsv = 1'b1; rsv_addr = 3'd3;
        tick();
        idle();
        raddr2 = 3'd6;
        #1;
        checks++;
        if (rdata1 !== 8'h00 || busy1 !== 1'b0 || busy2 !== 1'b0 || any_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdata=%h b1=%b b2=%b any=%b want 00/0/0/0",
                     rdata1, busy1, busy2, any_busy);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] exp_fwd;
        we = 1'b1; waddr = 3'd5; wdata = 8'h5C;
        tick();
        idle();
        raddr1 = 3'd5; raddr2 = 3'd5;
        #1;
        checks++;
        if (rdata1 !== 8'h5C || rdata2 !== 8'h5C) begin
            errors++;
            $display("FAIL write_read: r1=%h r2=%h want 5c/5c", rdata1, rdata2);
        end
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 8'h11;
`else
        exp_fwd = 8'h5C;
`endif
        we = 1'b1; waddr = 3'd5; wdata = 8'h11;
        #1;
        checks++;
        if (rdata1 !== exp_fwd || rdata2 !== exp_fwd) begin
            errors++;
            $display("FAIL same_cycle_read: r1=%h r2=%h want %h", rdata1, rdata2, exp_fwd);
        end
        tick();
        idle();
        checks++;
        if (rdata1 !== 8'h11) begin
            errors++;
            $display("FAIL after_write: r1=%h want 11", rdata1);
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF;
        rsv = 1'b1; rsv_addr = 3'd0;
        tick();
        idle();
        raddr1 = 3'd0; raddr2 = 3'd0;
        #1;
        checks++;
        if (rdata1 !== 8'h00 || busy1 !== 1'b0 || any_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: rdata=%h busy=%b any=%b want 00/0/0", rdata1, busy1, any_busy);
        end
        checks++;
        if (nz_rdata1 !== 8'hFF || nz_busy1 !== 1'b1 || nz_any_busy !== 1'b1) begin
            errors++;
            $display("FAIL nonzero_reg0: rdata=%h busy=%b any=%b want ff/1/1",
                     nz_rdata1, nz_busy1, nz_any_busy);
        end
        we = 1'b1; waddr = 3'd0; wdata = 8'h00;
        tick();
        idle();
        checks++;
        if (nz_busy1 !== 1'b0 || nz_any_busy !== 1'b0) begin
            errors++;
            $display("FAIL nonzero_release: busy=%b any=%b want 0/0", nz_busy1, nz_any_busy);
        end
    endtask

    task automatic test_scoreboard();
        rsv = 1'b1; rsv_addr = 3'd2;
        raddr1 = 3'd2; raddr2 = 3'd3;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rsv_latency: busy1=%b want 0", busy1);
        end
        tick();
        idle();
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b0 || any_busy !== 1'b1) begin
            errors++;
            $display("FAIL rsv_set: b1=%b b2=%b any=%b want 1/0/1", busy1, busy2, any_busy);
        end
        we = 1'b1; waddr = 3'd2; wdata = 8'h33;
        tick();
        idle();
        checks++;
        if (busy1 !== 1'b0 || any_busy !== 1'b0 || rdata1 !== 8'h33) begin
            errors++;
            $display("FAIL rsv_release: b1=%b any=%b rdata=%h want 0/0/33", busy1, any_busy, rdata1);
        end
    endtask

    task automatic test_collision();
        we = 1'b1; waddr = 3'd4; wdata = 8'h77;
        rsv = 1'b1; rsv_addr = 3'd4;
        tick();
        idle();
        raddr1 = 3'd4;
        #1;
        checks++;
        if (rdata1 !== 8'h77 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL collision: rdata=%h busy=%b want 77/1", rdata1, busy1);
        end
        we = 1'b1; waddr = 3'd1; wdata = 8'h12;
        rsv = 1'b1; rsv_addr = 3'd7;
        tick();
        idle();
        raddr1 = 3'd1; raddr2 = 3'd7;
        #1;
        checks++;
        if (rdata1 !== 8'h12 || busy1 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL independent: rdata=%h b1=%b b2=%b want 12/0/1", rdata1, busy1, busy2);
        end
        raddr2 = 3'd4;
        #1;
        checks++;
        if (busy2 !== 1'b1 || any_busy !== 1'b1) begin
            errors++;
            $display("FAIL collision_hold: b2=%b any=%b want 1/1", busy2, any_busy);
        end
        we = 1'b1; waddr = 3'd4; wdata = 8'h78;
        tick();
        we = 1'b1; waddr = 3'd7; wdata = 8'h9E;
        tick();
        idle();
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: any=%b want 0", any_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 1; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 8'(8'hA0 + i * 3);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            raddr1 = 3'(i); raddr2 = 3'(7 - i);
            exp = (i == 0) ? 8'h00 : 8'(8'hA0 + i * 3);
            #1;
            checks++;
            if (rdata1 !== exp) begin
                errors++;
                $display("FAIL b2b_r%0d: rdata=%h want %h", i, rdata1, exp);
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] exp;
        w_we = 1'b1; w_waddr = 4'd15; w_wdata = 16'hBEEF;
        tick();
        w_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_raddr1 = 4'(i); w_raddr2 = 4'(15 - i);
            exp = (i == 15) ? 16'hBEEF : 16'h0000;
            #1;
            checks++;
            if (w_rdata1 !== exp || w_busy1 !== 1'b0) begin
                errors++;
                $display("FAIL wide_r%0d: rdata=%h busy=%b want %h/0", i, w_rdata1, w_busy1, exp);
            end
        end
        checks++;
        if (w_any_busy !== 1'b0 || w_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL wide_busy: any=%b b2=%b want 0/0", w_any_busy, w_busy2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
